// File: rtl/sd_multi_reader.sv
// Multi-sector SD read sequencer: requests consecutive sectors from the byte-level
// sd_card core and streams every received byte into a linear cache.
module sd_multi_reader #(
    parameter int MAX_SECTORS = 16,
    parameter int SEC_BYTES   = 512,
    parameter int ADDR_W      = 14,
    parameter int CNT_W       = 5,
    parameter int TIMEOUT_W   = 24
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              card_present,
    input  logic              start,
    input  logic [31:0]       lba,
    input  logic [CNT_W-1:0]  count,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              init_ok,
    output logic              sd_rst_n,
    input  logic              sd_init,
    input  logic              sd_ready,
    output logic              sd_read,
    output logic [31:0]       sd_sec,
    input  logic [7:0]        sd_data,
    input  logic              sd_valid,
    output logic [7:0]        cache_data,
    output logic [ADDR_W-1:0] cache_addr,
    output logic              cache_we
);
    localparam int SB_W = $clog2(SEC_BYTES);

    typedef enum logic [2:0] {WAIT_INIT, IDLE, ARM, REQ, XFER, NEXT, ERR} state_t;

    state_t               state;
    logic [31:0]          lba_q;
    logic [CNT_W-1:0]     n_q;
    logic [CNT_W-1:0]     idx;
    logic [SB_W:0]        byte_cnt;
    logic                 overrun;
    logic [TIMEOUT_W-1:0] wd;
    logic                 valid_q;
    logic                 strobe;
    logic [CNT_W-1:0]     n_clamped;
    logic                 in_xfer;

    assign strobe    = sd_valid & ~valid_q;
    assign n_clamped = (count > CNT_W'(MAX_SECTORS)) ? CNT_W'(MAX_SECTORS) : count;
    assign in_xfer   = (state == ARM) || (state == REQ) || (state == XFER) || (state == NEXT);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state      <= WAIT_INIT;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            init_ok    <= 1'b0;
            sd_rst_n   <= 1'b0;
            sd_read    <= 1'b0;
            sd_sec     <= '0;
            cache_data <= '0;
            cache_addr <= '0;
            cache_we   <= 1'b0;
            lba_q      <= '0;
            n_q        <= '0;
            idx        <= '0;
            byte_cnt   <= '0;
            overrun    <= 1'b0;
            wd         <= '0;
            valid_q    <= 1'b0;
        end else begin
            sd_rst_n <= card_present;
            valid_q  <= sd_valid;
            done     <= 1'b0;
            cache_we <= 1'b0;
            wd       <= '0;
            if (state != WAIT_INIT && (!card_present || !sd_init)) begin
                if (busy) error <= 1'b1;
                busy    <= 1'b0;
                sd_read <= 1'b0;
                init_ok <= 1'b0;
                state   <= WAIT_INIT;
            end else if (abort && in_xfer) begin
                // An edge captured on the abort cycle is dropped, not written
                busy     <= 1'b0;
                sd_read  <= 1'b0;
                byte_cnt <= '0;
                overrun  <= 1'b0;
                state    <= IDLE;
            end else begin
                case (state)
                    WAIT_INIT: begin
                        init_ok <= 1'b0;
                        if (sd_init && card_present) begin
                            init_ok <= 1'b1;
                            state   <= IDLE;
                        end
                    end
                    IDLE: begin
                        init_ok <= 1'b1;
                        if (start) begin
                            error      <= 1'b0;
                            lba_q      <= lba;
                            n_q        <= n_clamped;
                            idx        <= '0;
                            byte_cnt   <= '0;
                            overrun    <= 1'b0;
                            cache_addr <= '0;
                            if (n_clamped == '0) begin
                                done <= 1'b1;
                            end else begin
                                busy  <= 1'b1;
                                state <= ARM;
                            end
                        end
                    end
                    ARM: begin
                        wd <= wd + TIMEOUT_W'(1);
                        if (sd_ready) begin
                            sd_read <= 1'b1;
                            sd_sec  <= lba_q + 32'(idx);
                            wd      <= '0;
                            state   <= REQ;
                        end else if (&wd) begin
                            wd    <= '0;
                            state <= ERR;
                        end
                    end
                    REQ: begin
                        wd <= wd + TIMEOUT_W'(1);
                        if (!sd_ready) begin
                            wd    <= '0;
                            state <= XFER;
                        end else if (&wd) begin
                            wd    <= '0;
                            state <= ERR;
                        end
                    end
                    XFER: begin
                        wd <= wd + TIMEOUT_W'(1);
                        if (sd_ready) begin
                            sd_read <= 1'b0;
                            wd      <= '0;
                            state   <= (byte_cnt == (SB_W+1)'(SEC_BYTES) && !overrun) ? NEXT : ERR;
                        end else if (strobe) begin
                            wd <= '0;
                            // Extra bytes are dropped but poison the sector
                            if (byte_cnt == (SB_W+1)'(SEC_BYTES)) begin
                                overrun <= 1'b1;
                            end else begin
                                cache_we   <= 1'b1;
                                cache_data <= sd_data;
                                cache_addr <= ADDR_W'({idx, byte_cnt[SB_W-1:0]});
                                byte_cnt   <= byte_cnt + (SB_W+1)'(1);
                            end
                        end else if (&wd) begin
                            wd    <= '0;
                            state <= ERR;
                        end
                    end
                    NEXT: begin
                        byte_cnt <= '0;
                        overrun  <= 1'b0;
                        idx      <= idx + CNT_W'(1);
                        if (idx + CNT_W'(1) == n_q) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            state <= ARM;
                        end
                    end
                    ERR: begin
                        error   <= 1'b1;
                        busy    <= 1'b0;
                        sd_read <= 1'b0;
                        state   <= IDLE;
                    end
                    default: state <= WAIT_INIT;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sd_multi_reader.sv
// Bench for sd_multi_reader: a behavioural SD core feeds random bytes and a
// scoreboard checks cache writes, sector addresses and status flags.
module tb_sd_multi_reader;
    localparam int SEC = 512, MAXS = 16, AW = 14, CW = 5, TW = 4;

    logic clk = 0, n_rst = 0, card_present = 1, start = 0, abort = 0;
    logic sd_init = 0, sd_ready = 1, sd_valid = 0;
    logic [31:0] lba = 0;
    logic [CW-1:0] count = 0;
    logic [7:0] sd_data = 0;
    logic busy, done, error, init_ok, sd_rst_n, sd_read, cache_we;
    logic [31:0] sd_sec;
    logic [7:0] cache_data;
    logic [AW-1:0] cache_addr;

    sd_multi_reader #(.MAX_SECTORS(MAXS), .SEC_BYTES(SEC), .ADDR_W(AW), .CNT_W(CW), .TIMEOUT_W(TW)) dut (
        .clk(clk), .n_rst(n_rst), .card_present(card_present), .start(start), .lba(lba),
        .count(count), .abort(abort), .busy(busy), .done(done), .error(error),
        .init_ok(init_ok), .sd_rst_n(sd_rst_n), .sd_init(sd_init), .sd_ready(sd_ready),
        .sd_read(sd_read), .sd_sec(sd_sec), .sd_data(sd_data), .sd_valid(sd_valid),
        .cache_data(cache_data), .cache_addr(cache_addr), .cache_we(cache_we)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    logic [AW+7:0] wr_q[$], exp_q[$];
    int done_cnt = 0, rd_cnt = 0;
    logic rd_prev = 0;
    always @(negedge clk) begin
        if (cache_we) wr_q.push_back({cache_addr, cache_data});
        if (done) done_cnt++;
        if (sd_read && !rd_prev) rd_cnt++;
        rd_prev <= sd_read;
    end

    // Core model for one sector; evt 1 = abort, 2 = card pull, at byte evt_at
    task automatic serve(input int sec_i, input logic [31:0] exp_sec, input int nbytes,
                         input int hold, input int evt, input int evt_at, output bit ok);
        int w = 0;
        ok = 0;
        while (!sd_read && w < 40) begin tick(); w++; end
        chk("req_seen", sd_read, 1);
        if (!sd_read) return;
        chk("sd_sec", sd_sec, exp_sec);
        tick($urandom_range(0, 2));
        sd_ready = 0;
        tick(1 + $urandom_range(0, 2));
        for (int j = 0; j < nbytes; j++) begin
            sd_data = 8'($urandom);
            if (evt != 0 && j == evt_at) begin
                if (evt == 1) begin sd_valid = 1; abort = 1; end
                else card_present = 0;
                tick();
                abort = 0; sd_valid = 0; sd_ready = 1;
                if (evt == 1) chk("abort_busy", busy, 0);
                else begin
                    chk("pull_err", error, 1);
                    chk("pull_init_ok", init_ok, 0);
                    chk("pull_sd_rst_n", sd_rst_n, 0);
                end
                chk("evt_sd_read", sd_read, 0);
                return;
            end
            sd_valid = 1;
            if (j < SEC) exp_q.push_back({AW'(sec_i * SEC + j), sd_data});
            tick(hold);
            sd_valid = 0;
            tick(1 + $urandom_range(0, 1));
        end
        sd_ready = 1;
        tick();
        ok = 1;
    endtask

    task automatic xfer(input string nm, input logic [31:0] b_lba, input int cnt, input int short_sec,
                        input int hold, input int evt, input int evt_at);
        int n = (cnt > MAXS) ? MAXS : cnt;
        int served = 0, w = 0, bad = 0;
        bit ok = 1;
        wr_q.delete(); exp_q.delete(); done_cnt = 0; rd_cnt = 0;
        lba = b_lba; count = CW'(cnt); start = 1;
        tick();
        start = 0;
        if (n == 0) chk({nm, ":done_next_cycle"}, done, 1);
        for (int s = 0; s < n && ok; s++) begin
            serve(s, b_lba + 32'(s), (s == short_sec) ? SEC - 1 : SEC, hold,
                  (s == 0) ? evt : 0, evt_at, ok);
            served++;
            if (s == short_sec) ok = 0;
        end
        while (busy && w < 40) begin tick(); w++; end
        tick(3);
        chk({nm, ":busy"}, busy, 0);
        chk({nm, ":writes"}, wr_q.size(), exp_q.size());
        for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++)
            if (wr_q[i] != exp_q[i]) bad++;
        chk({nm, ":write_mismatches"}, bad, 0);
        chk({nm, ":done_pulses"}, done_cnt, (evt == 0 && short_sec < 0) ? 1 : 0);
        chk({nm, ":error"}, error, (short_sec >= 0 || evt == 2) ? 1 : 0);
        chk({nm, ":requests"}, rd_cnt, served);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int c;
        tick(3);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_init_ok", init_ok, 0);
        chk("rst_sd_read", sd_read, 0);
        chk("rst_cache_we", cache_we, 0);
        chk("rst_sd_rst_n", sd_rst_n, 0);
        n_rst = 1;
        tick(10);
        chk("pre_init_ok", init_ok, 0);
        chk("sd_rst_n_up", sd_rst_n, 1);
        sd_init = 1;
        tick();
        chk("init_ok", init_ok, 1);

        xfer("three", 100, 3, -1, 1, 0, 0);
        xfer("zero", 32'h55, 0, -1, 1, 0, 0);
        xfer("clamp20", 32'hFFFF_FFF8, 20, -1, 1, 0, 0);
        xfer("short", 7, 3, 1, 1, 0, 0);
        xfer("hold3", 500, 2, -1, 3, 0, 0);
        xfer("abort", 9, 2, -1, 1, 1, 200);
        xfer("after_abort", 40, 1, -1, 1, 0, 0);

        // Core never ready: watchdog must end the transfer
        sd_ready = 0; done_cnt = 0; rd_cnt = 0;
        lba = 1; count = 1; start = 1;
        tick();
        start = 0;
        c = 0;
        while (!error && c < 40) begin tick(); c++; end
        chk("to_error", error, 1);
        chk("to_latency_in_window", (c >= 15 && c <= 19), 1);
        chk("to_busy", busy, 0);
        chk("to_requests", rd_cnt, 0);
        chk("to_done", done_cnt, 0);
        sd_ready = 1;
        tick();

        xfer("card_pull", 60, 2, -1, 1, 2, 100);
        card_present = 1;
        tick(2);
        chk("reinit_ok", init_ok, 1);
        chk("error_sticky", error, 1);
        xfer("final", $urandom, $urandom_range(1, 4), -1, $urandom_range(1, 2), 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
